// File: rtl/spi_controller.sv
// SPI mode-0 controller (CPOL=0, CPHA=0), MSB first, one fixed-length frame per start.
// Generates sclk and cs, shifts tx_data out on mosi and captures miso into rx_data.
// All outputs are registered; sclk is a divided copy of the system clock.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   start      frame request, accepted only while ready=1
//   tx_data    frame to send, captured on the accept cycle
//   ready      idle and able to accept start
//   done       one-cycle pulse at frame end; rx_data valid from this cycle
//   rx_data    last received frame, held until the next done
//   sclk       serial clock, idles low
//   cs         chip select, active low, idles high
//   mosi       serial data out
//   miso       serial data in, asynchronous to clk
module spi_controller #(
  parameter int unsigned data_length = 64,
  parameter int unsigned half_period = 4,
  parameter int unsigned cs_setup    = 2,
  parameter int unsigned cs_hold     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [data_length-1:0] tx_data,
  output logic                   ready,
  output logic                   done,
  output logic [data_length-1:0] rx_data,
  output logic                   sclk,
  output logic                   cs,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int unsigned MAX_A  = (half_period > cs_setup) ? half_period : cs_setup;
  localparam int unsigned MAX_PH = (MAX_A > cs_hold) ? MAX_A : cs_hold;
  localparam int unsigned PH_W   = $clog2(MAX_PH + 1);
  localparam int unsigned BIT_W  = $clog2(data_length);

  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(cs_setup - 1);
  localparam logic [PH_W-1:0]  HP_LAST    = PH_W'(half_period - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(cs_hold - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(data_length - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t                 state, state_d;
  logic [PH_W-1:0]        phase_cnt, phase_d;
  logic [BIT_W-1:0]       bit_cnt, bit_d;
  logic [data_length-1:0] shift_reg, shift_d;
  logic [data_length-1:0] rx_shift, rx_shift_d;
  logic [data_length-1:0] rx_data_d;
  logic                   mosi_d, done_d, cs_d, sclk_d, ready_d;
  logic                   miso_meta, miso_s;

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      mosi      <= 1'b0;
      done      <= 1'b0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      ready     <= 1'b1;
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      state     <= state_d;
      phase_cnt <= phase_d;
      bit_cnt   <= bit_d;
      shift_reg <= shift_d;
      rx_shift  <= rx_shift_d;
      rx_data   <= rx_data_d;
      mosi      <= mosi_d;
      done      <= done_d;
      cs        <= cs_d;
      sclk      <= sclk_d;
      ready     <= ready_d;
      miso_meta <= miso;
      miso_s    <= miso_meta;
    end
  end

  // Next-state and next-output logic; phase_cnt counts cycles spent in the current state
  always_comb begin
    state_d    = state;
    phase_d    = phase_cnt;
    bit_d      = bit_cnt;
    shift_d    = shift_reg;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    mosi_d     = mosi;
    done_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          shift_d = tx_data;
          bit_d   = '0;
          mosi_d  = tx_data[data_length-1];
          phase_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_cnt == SETUP_LAST) begin
          phase_d = '0;
          state_d = HIGH;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      HIGH: begin
        if (phase_cnt == HP_LAST) begin
          // Sample late in the high phase; the synchronised miso has long settled
          rx_shift_d = {rx_shift[data_length-2:0], miso_s};
          phase_d    = '0;
          if (bit_cnt == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            bit_d   = bit_cnt + BIT_W'(1);
            shift_d = {shift_reg[data_length-2:0], 1'b0};
            mosi_d  = shift_reg[data_length-2];
          end
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      LOW: begin
        if (phase_cnt == HP_LAST) begin
          phase_d = '0;
          state_d = HIGH;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      HOLD: begin
        if (phase_cnt == HOLD_LAST) begin
          phase_d   = '0;
          state_d   = GAP;
          done_d    = 1'b1;
          rx_data_d = rx_shift;
          mosi_d    = 1'b0;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      GAP: begin
        if (phase_cnt == HP_LAST) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_cnt + PH_W'(1);
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    // Pin levels follow the state being entered so they align with it once registered
    cs_d    = (state_d == IDLE) || (state_d == GAP);
    sclk_d  = (state_d == HIGH);
    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller (data_length=8, half_period=4, cs_setup=2, cs_hold=2).
// Stimulus pushes the expected rx_data per frame; a negedge monitor pops on done and
// also checks frame timing, mosi stability and a mode-0 peripheral model.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       ready, done, sclk, cs, mosi, miso;
  logic [7:0] rx_data;

  logic [1:0] mode;          // 0 loopback, 1 peripheral model, 2 tie 1, 3 tie 0
  logic [7:0] periph_word;
  logic       periph_miso;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  spi_controller #(
    .data_length(8),
    .half_period(4),
    .cs_setup(2),
    .cs_hold(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_data(tx_data),
    .ready(ready),
    .done(done),
    .rx_data(rx_data),
    .sclk(sclk),
    .cs(cs),
    .mosi(mosi),
    .miso(miso)
  );

  always #5 clk = ~clk;

  assign miso = (mode == 2'd0) ? mosi :
                (mode == 2'd1) ? periph_miso :
                (mode == 2'd2);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor state
  int         cycle = 0;
  int         done_cnt = 0;
  int         rises = 0;
  int         last_rise = 0;
  int         cs_low_cnt = 0;
  int         cs_high_cnt = 0;
  logic       seen_frame = 1'b0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  logic       prev_mosi = 1'b0;
  logic [7:0] p_tx = '0;
  logic [7:0] p_rx = '0;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      rises       = 0;
      cs_low_cnt  = 0;
      cs_high_cnt = 0;
      seen_frame  = 1'b0;
    end else begin
      // Mode-0 peripheral: loads on cs fall, samples on rise, shifts on fall
      if (!cs && prev_cs) begin
        if (seen_frame) check("cs_high_gap_ge4", 32'(cs_high_cnt >= 4), 32'd1);
        p_tx        = periph_word;
        p_rx        = '0;
        periph_miso = periph_word[7];
        rises       = 0;
        cs_low_cnt  = 0;
      end
      if (sclk && !prev_sclk) begin
        check("mosi_stable_at_rise", 32'(mosi), 32'(prev_mosi));
        if (rises > 0) check("sclk_period", 32'(cycle - last_rise), 32'd8);
        last_rise = cycle;
        rises++;
        p_rx = {p_rx[6:0], mosi};
      end
      if (!sclk && prev_sclk && !cs) begin
        p_tx        = {p_tx[6:0], 1'b0};
        periph_miso = p_tx[7];
      end
      if (!cs) cs_low_cnt++;
      else     cs_high_cnt++;
      if (cs && !prev_cs) begin
        check("cs_low_cycles", 32'(cs_low_cnt), 32'd64);
        check("sclk_rises", 32'(rises), 32'd8);
        seen_frame  = 1'b1;
        cs_high_cnt = 1;
      end
      if (done) begin
        done_cnt++;
        check("cs_high_at_done", 32'(cs), 32'd1);
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs;
    prev_mosi = mosi;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (ready) return;
      step();
    end
    check("timeout_ready", 32'd1, 32'd0);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt >= target) return;
      step();
    end
    check("timeout_done", 32'(done_cnt), 32'(target));
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] exp);
    wait_ready();
    tx_data = tx;
    start   = 1'b1;
    exp_q.push_back(exp);
    step();
    start = 1'b0;
    wait_done(done_cnt + 1);
  endtask

  int base;

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    tx_data     = '0;
    mode        = 2'd0;
    periph_word = '0;
    periph_miso = 1'b0;
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // 1: loopback
    mode = 2'd0;
    base = done_cnt;
    send(8'hA5, 8'hA5);
    repeat (20) step();
    check("t1_done_once", 32'(done_cnt - base), 32'd1);

    // 2: peripheral model returns 3C, receives C3
    mode        = 2'd1;
    periph_word = 8'h3C;
    send(8'hC3, 8'h3C);
    check("t2_periph_rx", 32'(p_rx), 32'hC3);

    // 3: start pulses while busy are ignored
    mode = 2'd0;
    base = done_cnt;
    wait_ready();
    tx_data = 8'h5A;
    start   = 1'b1;
    exp_q.push_back(8'h5A);
    step();
    start   = 1'b0;
    tx_data = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      repeat (7) step();
      check("t3_busy_not_ready", 32'(ready), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done(base + 1);
    repeat (40) step();
    check("t3_one_frame", 32'(done_cnt - base), 32'd1);

    // 4: start held high, back-to-back frames
    base = done_cnt;
    wait_ready();
    tx_data = 8'h01;
    start   = 1'b1;
    exp_q.push_back(8'h01);
    step();
    tx_data = 8'h80;
    exp_q.push_back(8'h80);
    step();
    wait_ready();
    step();
    start = 1'b0;
    wait_done(base + 2);
    check("t4_two_frames", 32'(done_cnt - base), 32'd2);

    // 5: reset at the 3rd sclk rise aborts the frame
    base = done_cnt;
    wait_ready();
    tx_data = 8'hA5;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rises == 3) break;
      step();
    end
    check("t5_reached_rise3", 32'(rises), 32'd3);
    rst = 1'b1;
    step();
    check("t5_cs", 32'(cs), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_mosi", 32'(mosi), 32'd0);
    check("t5_ready", 32'(ready), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (100) step();
    check("t5_no_done", 32'(done_cnt - base), 32'd0);

    // 6: miso tied high then low
    mode = 2'd2;
    send(8'h00, 8'hFF);
    repeat (10) step();
    check("t6_idle_sclk", 32'(sclk), 32'd0);
    check("t6_idle_cs", 32'(cs), 32'd1);
    mode = 2'd3;
    send(8'hFF, 8'h00);
    repeat (10) step();
    check("t6_idle_sclk2", 32'(sclk), 32'd0);
    check("t6_idle_cs2", 32'(cs), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
